// File: rtl/asynchronous_fifo_pkg.sv
// Shared sizing defaults and pointer-compare helpers for the single-clock FIFO.
// Pointers carry one extra wrap bit above the memory address.
package afifo_pkg;

  localparam int DEFAULT_DATA_SIZE = 8;
  localparam int DEFAULT_ADDR_SIZE = 3;

  // Pointers are zero-extended to 32 bits; only the low asz+1 bits take part.
  function automatic logic afifo_full(input logic [31:0] wp, input logic [31:0] rp,
                                      input int unsigned asz);
    logic [31:0] top_bit;
    logic [31:0] span;
    top_bit = 32'd1 << asz;
    span    = (top_bit << 1) - 32'd1;
    return ((wp ^ rp) & span) == top_bit;
  endfunction

  function automatic logic afifo_empty(input logic [31:0] wp, input logic [31:0] rp,
                                       input int unsigned asz);
    logic [31:0] span;
    span = (32'd2 << asz) - 32'd1;
    return ((wp ^ rp) & span) == 32'd0;
  endfunction

endpackage

// File: rtl/asynchronous_fifo_if.sv
// Producer/consumer bundle for the FIFO: push/pop requests, data and status flags.
// The slave modport is the FIFO side, the master modport is the user side.
interface asynchronous_fifo_if
  import afifo_pkg::*;
#(
  parameter int DataSize = DEFAULT_DATA_SIZE
);
  logic                Push;
  logic                Pop;
  logic [DataSize-1:0] DataIn;
  logic [DataSize-1:0] DataOut;
  logic                full;
  logic                empty;

  modport master (output Push, Pop, DataIn, input DataOut, full, empty);
  modport slave  (input Push, Pop, DataIn, output DataOut, full, empty);
endinterface

// File: rtl/afifo_mem.sv
// 2**AddrSize x DataSize storage: synchronous write with enable, combinational read.
// Contents are deliberately not reset.
module afifo_mem
  import afifo_pkg::*;
#(
  parameter int DataSize = DEFAULT_DATA_SIZE,
  parameter int AddrSize = DEFAULT_ADDR_SIZE
) (
  input  logic                Clk,
  input  logic                we_i,
  input  logic [AddrSize-1:0] waddr_i,
  input  logic [DataSize-1:0] wdata_i,
  input  logic [AddrSize-1:0] raddr_i,
  output logic [DataSize-1:0] rdata_o
);

  logic [DataSize-1:0] mem_q [2**AddrSize];

  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO: binary wrap-bit pointers, flags decoded from registered pointers.
// Build option FIFO_FWFT_EN selects a fall-through head word instead of a registered DataOut.
module asynchronous_fifo
  import afifo_pkg::*;
#(
  parameter int DataSize = DEFAULT_DATA_SIZE,
  parameter int AddrSize = DEFAULT_ADDR_SIZE
) (
  input  logic             Clk,
  input  logic             Resetn,
  asynchronous_fifo_if.slave bus
);

  logic [AddrSize:0]   WritePtr;
  logic [AddrSize:0]   ReadPtr;
  logic [AddrSize:0]   write_ptr_d;
  logic [AddrSize:0]   read_ptr_d;
  logic                full;
  logic                empty;
  logic                push_ok;
  logic                pop_ok;
  logic [DataSize-1:0] rd_data;

  assign full    = afifo_full(32'(WritePtr), 32'(ReadPtr), AddrSize);
  assign empty   = afifo_empty(32'(WritePtr), 32'(ReadPtr), AddrSize);
  assign push_ok = bus.Push && !full;
  assign pop_ok  = bus.Pop && !empty;

  assign bus.full  = full;
  assign bus.empty = empty;

  always_comb begin
    write_ptr_d = WritePtr;
    read_ptr_d  = ReadPtr;
    if (push_ok) begin
      write_ptr_d = WritePtr + 1'b1;
    end
    if (pop_ok) begin
      read_ptr_d = ReadPtr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      WritePtr <= '0;
      ReadPtr  <= '0;
    end else begin
      WritePtr <= write_ptr_d;
      ReadPtr  <= read_ptr_d;
    end
  end

  // Writes are blocked while reset is held so a discarded push cannot land in memory.
  afifo_mem #(
    .DataSize (DataSize),
    .AddrSize (AddrSize)
  ) u_mem (
    .Clk     (Clk),
    .we_i    (push_ok && Resetn),
    .waddr_i (WritePtr[AddrSize-1:0]),
    .wdata_i (bus.DataIn),
    .raddr_i (ReadPtr[AddrSize-1:0]),
    .rdata_o (rd_data)
  );

`ifdef FIFO_FWFT_EN
  assign bus.DataOut = empty ? '0 : rd_data;
`else
  logic [DataSize-1:0] data_out_q;
  logic [DataSize-1:0] data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (pop_ok) begin
      data_out_d = rd_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign bus.DataOut = data_out_q;
`endif

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Directed bench for asynchronous_fifo in its default (registered DataOut) build.
// Inputs change #1 after a rising edge; outputs are sampled at the same point.
module tb_asynchronous_fifo;

  logic Clk;
  logic Resetn;
  int   tests;
  int   fails;

  asynchronous_fifo_if #(.DataSize(8)) bus ();

  asynchronous_fifo #(
    .DataSize (8),
    .AddrSize (3)
  ) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    bus.Push   = p;
    bus.Pop    = q;
    bus.DataIn = d;
    @(posedge Clk);
    #1;
    bus.Push = 1'b0;
    bus.Pop  = 1'b0;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    @(posedge Clk);
    #1;
    Resetn = 1'b1;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    bus.Push   = 1'b0;
    bus.Pop    = 1'b0;
    bus.DataIn = 8'd0;
    Resetn     = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Resetn = 1'b1;
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_dout", 32'(bus.DataOut), 0);
    check("rst_wptr", 32'(dut.WritePtr), 0);
    check("rst_rptr", 32'(dut.ReadPtr), 0);

    // single push then pop
    cyc(1'b1, 1'b0, 8'd10);
    check("p1_empty", 32'(bus.empty), 0);
    check("p1_full", 32'(bus.full), 0);
    check("p1_wptr", 32'(dut.WritePtr), 1);
    cyc(1'b0, 1'b1, 8'd0);
    check("p1_dout", 32'(bus.DataOut), 10);
    check("p1_empty_after", 32'(bus.empty), 1);

    // fill to full from a clean reset
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      check($sformatf("fill_full_%0d", i), 32'(bus.full), (i == 8) ? 1 : 0);
    end
    check("fill_wptr", 32'(dut.WritePtr), 8);
    cyc(1'b1, 1'b0, 8'd99);
    check("ovf_wptr", 32'(dut.WritePtr), 8);
    check("ovf_full", 32'(bus.full), 1);

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      check($sformatf("drain_dout_%0d", i), 32'(bus.DataOut), i);
      check($sformatf("drain_empty_%0d", i), 32'(bus.empty), (i == 8) ? 1 : 0);
    end
    cyc(1'b0, 1'b1, 8'd0);
    check("udf_dout", 32'(bus.DataOut), 8);
    check("udf_rptr", 32'(dut.ReadPtr), 8);

    // simultaneous push+pop: empty, half-full, full
    cyc(1'b1, 1'b1, 8'd20);
    check("pp_empty_dout", 32'(bus.DataOut), 8);
    check("pp_empty_occ", 32'(4'(dut.WritePtr - dut.ReadPtr)), 1);
    for (int i = 21; i <= 23; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b1, 8'd24);
    check("pp_half_dout", 32'(bus.DataOut), 20);
    check("pp_half_occ", 32'(4'(dut.WritePtr - dut.ReadPtr)), 4);
    for (int i = 25; i <= 28; i++) cyc(1'b1, 1'b0, 8'(i));
    check("pp_full_pre", 32'(bus.full), 1);
    check("pp_full_wptr_wrap", 32'(dut.WritePtr), 1);
    cyc(1'b1, 1'b1, 8'd99);
    check("pp_full_dout", 32'(bus.DataOut), 21);
    check("pp_full_occ", 32'(4'(dut.WritePtr - dut.ReadPtr)), 7);
    check("pp_full_flag", 32'(bus.full), 0);
    for (int i = 22; i <= 28; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      check($sformatf("pp_order_%0d", i), 32'(bus.DataOut), i);
    end
    check("pp_final_empty", 32'(bus.empty), 1);

    // streaming across pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 8'(100 + i));
      check($sformatf("wrap_ne_%0d", i), 32'(bus.empty), 0);
      cyc(1'b0, 1'b1, 8'd0);
      check($sformatf("wrap_dout_%0d", i), 32'(bus.DataOut), 100 + i);
      check($sformatf("wrap_e_%0d", i), 32'(bus.empty), 1);
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(50 + i));
    check("wrap_full", 32'(bus.full), 1);
    check("wrap_full_wptr", 32'(dut.WritePtr), 13);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      check($sformatf("wrap_fill_dout_%0d", i), 32'(bus.DataOut), 50 + i);
    end
    check("wrap_fill_empty", 32'(bus.empty), 1);

    // reset mid-operation with 5 words held and a push pending
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(60 + i));
    cyc(1'b0, 1'b1, 8'd0);
    check("mid_dout_pre", 32'(bus.DataOut), 60);
    bus.Push   = 1'b1;
    bus.DataIn = 8'd55;
    do_reset();
    bus.Push = 1'b0;
    check("mid_empty", 32'(bus.empty), 1);
    check("mid_full", 32'(bus.full), 0);
    check("mid_dout", 32'(bus.DataOut), 0);
    check("mid_wptr", 32'(dut.WritePtr), 0);
    cyc(1'b1, 1'b0, 8'd77);
    check("post_wptr", 32'(dut.WritePtr), 1);
    cyc(1'b0, 1'b1, 8'd0);
    check("post_dout", 32'(bus.DataOut), 77);
    check("post_rptr", 32'(dut.ReadPtr), 1);
    check("post_empty", 32'(bus.empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
